// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions: funct3 format codes, access sizes and the size decoder.
package load_store_unit_pkg;

    localparam int DATA_BITS = 32;

    localparam logic [2:0] FMT_B  = 3'b000;
    localparam logic [2:0] FMT_H  = 3'b001;
    localparam logic [2:0] FMT_W  = 3'b010;
    localparam logic [2:0] FMT_BU = 3'b100;
    localparam logic [2:0] FMT_HU = 3'b101;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    // Only funct3[1:0] selects the width; 011 and 11x fall through to a word access.
    function automatic size_e size_of(input logic [1:0] width_code);
        case (width_code)
            2'b00:   return SIZE_B;
            2'b01:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response plus data_memory port of the load/store unit, bundled as one interface.
interface load_store_unit_if #(
    parameter int ADDR_BITS = 32
) ();
    logic                 read_enable;
    logic                 write_enable;
    logic [2:0]           data_format;
    logic [31:0]          address;
    logic [31:0]          write_data;
    logic [31:0]          read_data;
    logic                 busy;
    logic                 misaligned_fault;
    logic [ADDR_BITS-3:0] mem_address;
    logic [3:0]           mem_byteena;
    logic [31:0]          mem_data;
    logic                 mem_wren;
    logic [31:0]          mem_q;

    // master: the core and memory environment around the unit
    modport master (
        output read_enable, write_enable, data_format, address, write_data, mem_q,
        input  read_data, busy, misaligned_fault, mem_address, mem_byteena, mem_data, mem_wren
    );

    // slave: the load/store unit itself
    modport slave (
        input  read_enable, write_enable, data_format, address, write_data, mem_q,
        output read_data, busy, misaligned_fault, mem_address, mem_byteena, mem_data, mem_wren
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable mask, store data shift, load shift and sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  data_format,
    input  logic [1:0]  offset,
    input  logic [31:0] write_data,
    input  logic [63:0] read_pair,
    output logic [7:0]  mask8,
    output logic [63:0] wd64,
    output logic [31:0] load_data
);
    size_e       size;
    logic [3:0]  base_mask;
    logic [31:0] load_word;
    logic        sign_en;

    always_comb begin
        size = size_of(data_format[1:0]);
        case (size)
            SIZE_B:  base_mask = 4'b0001;
            SIZE_H:  base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        mask8     = {4'b0000, base_mask} << offset;
        wd64      = {32'b0, write_data} << {offset, 3'b000};
        load_word = 32'(read_pair >> {offset, 3'b000});
        sign_en   = ~data_format[2];
        case (size)
            SIZE_B:  load_data = {{24{sign_en & load_word[7]}}, load_word[7:0]};
            SIZE_H:  load_data = {{16{sign_en & load_word[15]}}, load_word[15:0]};
            default: load_data = load_word;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store front end of data_memory: word-crossing accesses are split into two cycles by a small FSM.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_BITS     = DATA_BITS,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam int WORD_BITS = ADDR_BITS - 2;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SECOND = 1'b1;

    logic [0:0]           state_reg, state_next;
    logic [31:0]          saved_low_reg, saved_low_next;
    logic [WORD_BITS-1:0] word_a, word_b;
    logic [7:0]           mask8;
    logic [63:0]          wd64;
    logic [63:0]          read_pair;
    logic [31:0]          load_data;
    logic                 request, crossing, fault;

    assign word_a   = bus.address[ADDR_BITS-1:2];
    assign word_b   = word_a + {{(WORD_BITS-1){1'b0}}, 1'b1};
    assign request  = bus.read_enable | bus.write_enable;
    assign crossing = |mask8[7:4];
    assign fault    = request & crossing & (MISALIGNED_EN == 1'b0);

    // Second half of a split load joins the saved first word below the live memory word.
    assign read_pair = (state_reg == SECOND) ? {bus.mem_q, saved_low_reg} : {32'b0, bus.mem_q};

    lsu_align u_align (
        .data_format (bus.data_format),
        .offset      (bus.address[1:0]),
        .write_data  (bus.write_data),
        .read_pair   (read_pair),
        .mask8       (mask8),
        .wd64        (wd64),
        .load_data   (load_data)
    );

    always_comb begin
        state_next       = state_reg;
        saved_low_next   = saved_low_reg;
        bus.mem_address  = word_a;
        bus.mem_byteena  = 4'b0000;
        bus.mem_data     = wd64[31:0];
        bus.mem_wren     = 1'b0;
        bus.busy         = 1'b0;
        if (state_reg == IDLE) begin
            if (request && !fault) begin
                bus.mem_byteena = mask8[3:0];
                bus.mem_wren    = bus.write_enable;
                if (crossing) begin
                    bus.busy       = 1'b1;
                    saved_low_next = bus.mem_q;
                    state_next     = SECOND;
                end
            end
        end else begin
            bus.mem_address = word_b;
            bus.mem_byteena = mask8[7:4];
            bus.mem_data    = wd64[63:32];
            // A reset landing here must not complete the second half of a store.
            bus.mem_wren    = bus.write_enable & ~reset;
            state_next      = IDLE;
        end
        bus.read_data        = (bus.read_enable && !fault) ? load_data : 32'b0;
        bus.misaligned_fault = fault;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            saved_low_reg <= 32'b0;
        end else begin
            state_reg     <= state_next;
            saved_low_reg <= saved_low_next;
        end
    end
endmodule
